// File: rtl/adc_stream_router.sv
// Routes NCH ADC channels onto NOUT FIFO write ports in whole frames of FRAME_LEN samples,
// with frame-boundary source switching and a saturating overflow count.
module adc_stream_router #(
   parameter int NCH       = 4,
   parameter int NOUT      = 2,
   parameter int DW        = 16,
   parameter int FRAME_LEN = 256,
   parameter int SELW      = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          sample_cs,
   input  logic [NCH*DW-1:0]             ch_data,
   input  logic                          sel_wr,
   input  logic [NOUT*SELW-1:0]          sel_in,
   input  logic [NOUT-1:0]               fifo_full,
   output logic [NOUT*DW-1:0]            out_data,
   output logic                          out_wr,
   output logic                          frame_start,
   output logic                          active,
   output logic [NOUT*SELW-1:0]          cur_sel,
   output logic [$clog2(FRAME_LEN)-1:0]  sample_cnt,
   output logic [15:0]                   overflow_cnt
);

   localparam int CW = $clog2(FRAME_LEN);

   typedef enum logic [1:0] {IDLE, ARMED, RUN, SKIP} state_t;

   state_t                 state;
   logic                   s1, s2, s3;
   logic                   strb;
   logic                   boundary;
   logic                   any_full;
   logic                   last;
   logic [NOUT*SELW-1:0]   pend_sel;
   logic [NOUT*SELW-1:0]   pend_eff;
   logic [NOUT*SELW-1:0]   sel_use;

   // Out-of-range selectors never match a channel and so leave that output at zero.
   function automatic logic [NOUT*DW-1:0] route(input logic [NCH*DW-1:0]    d,
                                                input logic [NOUT*SELW-1:0] s);
      logic [NOUT*DW-1:0] r;
      logic [SELW-1:0]    idx;
      r = '0;
      for (int o = 0; o < NOUT; o++) begin
         idx = s[o*SELW +: SELW];
         for (int c = 0; c < NCH; c++) begin
            if (idx == SELW'(c)) r[o*DW +: DW] = d[c*DW +: DW];
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign strb     = s2 & ~s3;
   assign any_full = |fifo_full;
   assign last     = (sample_cnt == CW'(FRAME_LEN - 1));
   assign boundary = strb && (state == ARMED) && (sample_cnt == '0);
   // A selector written in the same cycle as the boundary strobe takes effect on that sample.
   assign pend_eff = sel_wr ? sel_in : pend_sel;
   assign sel_use  = boundary ? pend_eff : cur_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         s1           <= 1'b0;
         s2           <= 1'b0;
         s3           <= 1'b0;
         pend_sel     <= '0;
         cur_sel      <= '0;
         out_data     <= '0;
         out_wr       <= 1'b0;
         frame_start  <= 1'b0;
         active       <= 1'b0;
         sample_cnt   <= '0;
         overflow_cnt <= '0;
      end else begin
         s1          <= sample_cs;
         s2          <= s1;
         s3          <= s2;
         out_wr      <= 1'b0;
         frame_start <= 1'b0;
         if (sel_wr) pend_sel <= sel_in;
         if (state == IDLE || boundary) cur_sel <= pend_eff;

         case (state)
            IDLE: begin
               if (enable) begin
                  state  <= ARMED;
                  active <= 1'b1;
               end
            end
            ARMED: begin
               if (!enable) begin
                  state  <= IDLE;
                  active <= 1'b0;
               end else if (boundary) begin
                  frame_start <= 1'b1;
                  sample_cnt  <= sample_cnt + 1'b1;
                  if (any_full) begin
                     state        <= SKIP;
                     overflow_cnt <= sat_inc(overflow_cnt);
                  end else begin
                     state    <= RUN;
                     out_wr   <= 1'b1;
                     out_data <= route(ch_data, sel_use);
                  end
               end
            end
            RUN, SKIP: begin
               if (strb) begin
                  // Dropped samples still advance the count so all outputs stay frame-aligned.
                  sample_cnt <= sample_cnt + 1'b1;
                  if (state == RUN && !any_full) begin
                     out_wr   <= 1'b1;
                     out_data <= route(ch_data, sel_use);
                  end else begin
                     overflow_cnt <= sat_inc(overflow_cnt);
                  end
                  if (last) begin
                     state  <= enable ? ARMED : IDLE;
                     active <= enable;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_stream_router.sv
// Scoreboard bench for adc_stream_router: expected writes are queued per CS edge and
// matched against each out_wr pulse, including the 3-clock latency.
module tb_adc_stream_router;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        sample_cs;
   logic [63:0] ch_data;
   logic        sel_wr;
   logic [5:0]  sel_in;
   logic [1:0]  fifo_full;
   logic [31:0] out_data;
   logic        out_wr;
   logic        frame_start;
   logic        active;
   logic [5:0]  cur_sel;
   logic [7:0]  sample_cnt;
   logic [15:0] overflow_cnt;

   typedef struct {
      logic [15:0] d0;
      logic [15:0] d1;
      logic        fs;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   n_wr  = 0;
   int   n_fs  = 0;
   int   cyc   = 0;
   int   wr0;
   int   fs0;

   adc_stream_router dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .sample_cs    (sample_cs),
      .ch_data      (ch_data),
      .sel_wr       (sel_wr),
      .sel_in       (sel_in),
      .fifo_full    (fifo_full),
      .out_data     (out_data),
      .out_wr       (out_wr),
      .frame_start  (frame_start),
      .active       (active),
      .cur_sel      (cur_sel),
      .sample_cnt   (sample_cnt),
      .overflow_cnt (overflow_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (frame_start) n_fs++;
      if (out_wr) begin
         n_wr++;
         if (sb.size() == 0) begin
            check_val("unexpected_wr", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check_val("out0", {16'h0, out_data[15:0]}, {16'h0, mon_e.d0});
            check_val("out1", {16'h0, out_data[31:16]}, {16'h0, mon_e.d1});
            check_val("fs_on_wr", {31'h0, frame_start}, {31'h0, mon_e.fs});
            check_val("latency", cyc - mon_e.cyc, 32'd3);
         end
      end
   end

   // Caller is at a negedge; the edge period is hi+lo clocks.
   task automatic cs_edge(input bit wr, input logic [15:0] d0, input logic [15:0] d1,
                          input bit fs, input int hi, input int lo);
      exp_t e;
      if (wr) begin
         e.d0 = d0; e.d1 = d1; e.fs = fs; e.cyc = cyc;
         sb.push_back(e);
      end
      sample_cs = 1'b1;
      repeat (hi) @(negedge clk);
      sample_cs = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic load_sel(input logic [5:0] s);
      sel_in = s;
      sel_wr = 1'b1;
      @(negedge clk);
      sel_wr = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      enable    = 1'b0;
      sample_cs = 1'b0;
      sel_wr    = 1'b0;
      sel_in    = '0;
      fifo_full = '0;
      ch_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      repeat (3) @(negedge clk);
      check_val("rst_wr", {31'h0, out_wr}, 32'd0);
      check_val("rst_active", {31'h0, active}, 32'd0);
      check_val("rst_data", out_data, 32'd0);
      check_val("rst_misc", {frame_start, cur_sel, sample_cnt, overflow_cnt}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      load_sel({3'd2, 3'd0});
      @(negedge clk);
      check_val("idle_sel", {26'h0, cur_sel}, {26'h0, 3'd2, 3'd0});
      enable = 1'b1;
      repeat (2) @(negedge clk);
      check_val("armed_active", {31'h0, active}, 32'd1);

      // Basic routing frame
      wr0 = n_wr; fs0 = n_fs;
      for (int i = 0; i < 256; i++) cs_edge(1'b1, 16'h1111, 16'h3333, i == 0, 2, 2);
      check_val("f1_writes", n_wr - wr0, 32'd256);
      check_val("f1_fs", n_fs - fs0, 32'd1);
      check_val("f1_cnt", {24'h0, sample_cnt}, 32'd0);
      check_val("f1_active", {31'h0, active}, 32'd1);

      // New selection written mid-frame must wait for the boundary
      for (int i = 0; i < 256; i++) begin
         if (i == 100) load_sel({3'd3, 3'd1});
         cs_edge(1'b1, 16'h1111, 16'h3333, i == 0, 2, 2);
      end
      check_val("f2_sel_held", {26'h0, cur_sel}, {26'h0, 3'd2, 3'd0});

      // Switched routing, mid-frame full on strobes 10..14
      wr0 = n_wr;
      for (int i = 0; i < 256; i++) begin
         fifo_full = (i >= 10 && i <= 14) ? 2'b01 : 2'b00;
         if (i == 200) load_sel({3'd5, 3'd0});
         cs_edge(!(i >= 10 && i <= 14), 16'h2222, 16'h4444, i == 0, 2, 2);
      end
      fifo_full = 2'b00;
      check_val("f3_writes", n_wr - wr0, 32'd251);
      check_val("f3_ovf", {16'h0, overflow_cnt}, 32'd5);
      check_val("f3_cnt", {24'h0, sample_cnt}, 32'd0);
      check_val("f3_sel", {26'h0, cur_sel}, {26'h0, 3'd3, 3'd1});

      // Full at frame start discards the whole frame
      wr0 = n_wr; fs0 = n_fs;
      for (int i = 0; i < 256; i++) begin
         fifo_full = (i == 0) ? 2'b10 : 2'b00;
         cs_edge(1'b0, 16'h0, 16'h0, 1'b0, 2, 2);
      end
      check_val("f4_writes", n_wr - wr0, 32'd0);
      check_val("f4_fs", n_fs - fs0, 32'd1);
      check_val("f4_ovf", {16'h0, overflow_cnt}, 32'd261);
      check_val("f4_sel", {26'h0, cur_sel}, {26'h0, 3'd5, 3'd0});

      // Normal frame with out-of-range selector; enable dropped at sample 50
      wr0 = n_wr;
      for (int i = 0; i < 256; i++) begin
         if (i == 50) enable = 1'b0;
         cs_edge(1'b1, 16'h1111, 16'h0000, i == 0, 2, 2);
      end
      check_val("f5_writes", n_wr - wr0, 32'd256);
      check_val("f5_active", {31'h0, active}, 32'd0);
      wr0 = n_wr;
      for (int i = 0; i < 3; i++) cs_edge(1'b0, 16'h0, 16'h0, 1'b0, 2, 2);
      check_val("idle_writes", n_wr - wr0, 32'd0);
      check_val("idle_cnt", {24'h0, sample_cnt}, 32'd0);

      // Strobe detect: long high pulse, then 4-clock back-to-back edges
      enable = 1'b1;
      repeat (2) @(negedge clk);
      wr0 = n_wr;
      cs_edge(1'b1, 16'h1111, 16'h0000, 1'b1, 10, 3);
      check_val("long_cs_writes", n_wr - wr0, 32'd1);
      wr0 = n_wr;
      for (int i = 0; i < 5; i++) cs_edge(1'b1, 16'h1111, 16'h0000, 1'b0, 2, 2);
      check_val("b2b_writes", n_wr - wr0, 32'd5);
      check_val("b2b_cnt", {24'h0, sample_cnt}, 32'd6);

      // Asynchronous reset while a write pulse is on the outputs
      sample_cs = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("pre_rst_wr", {31'h0, out_wr}, 32'd1);
      rst = 1'b1;
      #1;
      check_val("arst_wr", {31'h0, out_wr}, 32'd0);
      check_val("arst_cnt", {24'h0, sample_cnt}, 32'd0);
      check_val("arst_ovf", {16'h0, overflow_cnt}, 32'd0);
      check_val("arst_sel", {26'h0, cur_sel}, 32'd0);
      check_val("arst_data", out_data, 32'd0);
      @(negedge clk);
      sample_cs = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("sb_empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
